blk_ctrl_monitor: RTL and testbench

Synthesizable, parametrised successor to the single-block ap_ctrl trace monitor. It observes NUM_CH independent HLS ap_ctrl_hs/ap_ctrl_chain handshakes. Per channel it counts accepted transactions and completions, tracks outstanding work and measures start-to-done latency. On a finish pulse it checks the final counts against programmed expected counts. It sits beside the accelerator top level as a debug/verification observer and never drives the ap_* signals.

---
 rtl/blk_ctrl_monitor.sv | 107 ++++++++++
 tb/tb_blk_ctrl_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_ctrl_monitor.sv
// blk_ctrl_monitor: per-channel ap_ctrl handshake observer with counters, latency tracking and end-of-run check
module blk_ctrl_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int LAT_W      = 24,
  parameter int MAX_OUT    = 4,
  parameter int CHAIN_MODE = 0
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_CH-1:0]                           ap_start,
  input  logic [NUM_CH-1:0]                           ap_ready,
  input  logic [NUM_CH-1:0]                           ap_done,
  input  logic [NUM_CH-1:0]                           ap_continue,
  input  logic                                        clear,
  input  logic                                        cfg_we,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                            cfg_exp,
  input  logic                                        finish,
  input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  input  logic [1:0]                                  rd_sel,
  output logic [CNT_W-1:0]                            rd_data,
  output logic                                        chk_done,
  output logic [NUM_CH-1:0]                           chk_fail,
  output logic [NUM_CH-1:0]                           proto_err,
  output logic [NUM_CH-1:0]                           cnt_ovf
);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t             state     [NUM_CH];
  logic [OUT_W-1:0]   outst     [NUM_CH];
  logic [LAT_W-1:0]   lat_cnt   [NUM_CH];
  logic [LAT_W-1:0]   lat_nxt   [NUM_CH];
  logic [LAT_W-1:0]   last_lat  [NUM_CH];
  logic [LAT_W-1:0]   max_lat   [NUM_CH];
  logic [CNT_W-1:0]   trans_cnt [NUM_CH];
  logic [CNT_W-1:0]   done_cnt  [NUM_CH];
  logic [CNT_W-1:0]   exp_cnt   [NUM_CH];
  logic [NUM_CH-1:0]  acc, cmp;
  logic [CNT_W-1:0]   rd_val;
  assign acc = ap_start & ap_ready;
  assign cmp = ap_done & (CHAIN_MODE != 0 ? ap_continue : '1);
  // saturating next latency value and readout mux
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) lat_nxt[i] = &lat_cnt[i] ? lat_cnt[i] : lat_cnt[i] + 1'b1;
    rd_val = '0;
    if (int'(rd_ch) < NUM_CH)
      rd_val = rd_sel == 2'd0 ? trans_cnt[rd_ch] :
               rd_sel == 2'd1 ? done_cnt[rd_ch] :
               rd_sel == 2'd2 ? CNT_W'(last_lat[rd_ch]) : CNT_W'(max_lat[rd_ch]);
  end
  // per-channel handshake tracking, check on finish, registered readout
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i]     <= IDLE;
        outst[i]     <= '0;
        lat_cnt[i]   <= '0;
        last_lat[i]  <= '0;
        max_lat[i]   <= '0;
        trans_cnt[i] <= '0;
        done_cnt[i]  <= '0;
        if (!rst_n) exp_cnt[i] <= '0;
      end
      rd_data   <= '0;
      chk_done  <= 1'b0;
      chk_fail  <= '0;
      proto_err <= '0;
      cnt_ovf   <= '0;
    end else begin
      rd_data  <= rd_val;
      chk_done <= finish;
      if (cfg_we && int'(cfg_ch) < NUM_CH) exp_cnt[cfg_ch] <= cfg_exp;
      for (int i = 0; i < NUM_CH; i++) begin
        if (finish)
          chk_fail[i] <= chk_fail[i] | (trans_cnt[i] != exp_cnt[i]) | (done_cnt[i] != trans_cnt[i]) |
                         (outst[i] != '0) | proto_err[i] | cnt_ovf[i];
        if (acc[i]) begin
          if (&trans_cnt[i]) cnt_ovf[i] <= 1'b1;
          else trans_cnt[i] <= trans_cnt[i] + 1'b1;
        end
        if (cmp[i]) begin
          if (&done_cnt[i]) cnt_ovf[i] <= 1'b1;
          else done_cnt[i] <= done_cnt[i] + 1'b1;
        end
        if (acc[i] && !cmp[i]) begin
          if (outst[i] == OUT_W'(MAX_OUT)) proto_err[i] <= 1'b1;
          else outst[i] <= outst[i] + 1'b1;
          lat_cnt[i] <= state[i] == IDLE ? '0 : lat_nxt[i];
          state[i]   <= BUSY;
        end else if (cmp[i] && !acc[i] && state[i] == IDLE) begin
          proto_err[i] <= 1'b1;
        end else if (cmp[i]) begin
          last_lat[i] <= state[i] == IDLE ? '0 : lat_nxt[i];
          max_lat[i]  <= state[i] == BUSY && lat_nxt[i] > max_lat[i] ? lat_nxt[i] : max_lat[i];
          lat_cnt[i]  <= '0;
          if (!acc[i]) begin
            outst[i] <= outst[i] - 1'b1;
            state[i] <= outst[i] == OUT_W'(1) ? IDLE : BUSY;
          end
        end else if (state[i] == BUSY) begin
          lat_cnt[i] <= lat_nxt[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_blk_ctrl_monitor.sv
// tb_blk_ctrl_monitor: scoreboard bench for two blk_ctrl_monitor configurations
module tb_blk_ctrl_monitor;
  logic        clk = 1'b0;
  logic        rst_n, clear, cfg_we, finish_a, finish_b, probe, probe_q;
  logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
  logic [1:0]  cfg_ch, rd_ch, rd_sel;
  logic [31:0] cfg_exp;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b;
  logic        chk_done_a, chk_done_b;
  logic [3:0]  chk_fail_a, chk_fail_b, proto_err_a, proto_err_b, cnt_ovf_a, cnt_ovf_b;
  int errors = 0, checks = 0;
  int nchk_a = 0, nchk_b = 0, fa_cnt = 0, fb_cnt = 0;
  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic [3:0]  pe;
    logic [3:0]  ov;
    string       nm;
  } exp_t;
  exp_t        pq[$];
  exp_t        e;
  logic [3:0]  cqa[$], cqb[$];
  logic [3:0]  cf;

  always #5 clk = ~clk;

  blk_ctrl_monitor u_a (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .clear(clear), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_exp(cfg_exp),
    .finish(finish_a), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data_a), .chk_done(chk_done_a),
    .chk_fail(chk_fail_a), .proto_err(proto_err_a), .cnt_ovf(cnt_ovf_a)
  );

  blk_ctrl_monitor #(.CNT_W(4), .LAT_W(8), .CHAIN_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .clear(clear), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_exp(cfg_exp[3:0]),
    .finish(finish_b), .rd_ch(rd_ch), .rd_sel(rd_sel), .rd_data(rd_data_b), .chk_done(chk_done_b),
    .chk_fail(chk_fail_b), .proto_err(proto_err_b), .cnt_ovf(cnt_ovf_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, ex);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic step(input logic [3:0] acc, input logic [3:0] dn, input logic [3:0] ct);
    ap_start = acc;
    ap_ready = acc;
    ap_done = dn;
    ap_continue = ct;
    cyc();
    ap_start = '0;
    ap_ready = '0;
    ap_done = '0;
    ap_continue = '0;
  endtask

  task automatic rd(input int inst, input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] val,
                    input logic [3:0] pe, input logic [3:0] ov, input string nm);
    exp_t x;
    x.inst = inst;
    x.rd = val;
    x.pe = pe;
    x.ov = ov;
    x.nm = nm;
    pq.push_back(x);
    rd_ch = ch;
    rd_sel = sel;
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic fin(input logic do_a, input logic [3:0] ea, input logic do_b, input logic [3:0] eb);
    if (do_a) begin cqa.push_back(ea); fa_cnt++; end
    if (do_b) begin cqb.push_back(eb); fb_cnt++; end
    finish_a = do_a;
    finish_b = do_b;
    cyc();
    finish_a = 1'b0;
    finish_b = 1'b0;
    idle(3);
    if (do_a) chk("chk_done_a pulses", nchk_a, fa_cnt);
    if (do_b) chk("chk_done_b pulses", nchk_b, fb_cnt);
  endtask

  always @(posedge clk) probe_q <= probe;

  // monitor: pops probe expectations one edge after a probe, and check expectations on chk_done
  always @(negedge clk) begin
    if (probe_q) begin
      if (pq.size() == 0) chk("unexpected probe", 1, 0);
      else begin
        e = pq.pop_front();
        chk({e.nm, " rd_data"}, e.inst == 0 ? rd_data_a : {28'b0, rd_data_b}, e.rd);
        chk({e.nm, " proto_err"}, {28'b0, e.inst == 0 ? proto_err_a : proto_err_b}, {28'b0, e.pe});
        chk({e.nm, " cnt_ovf"}, {28'b0, e.inst == 0 ? cnt_ovf_a : cnt_ovf_b}, {28'b0, e.ov});
      end
    end
    if (chk_done_a) begin
      nchk_a++;
      if (cqa.size() == 0) chk("unexpected chk_done_a", 1, 0);
      else begin
        cf = cqa.pop_front();
        chk("chk_fail_a", {28'b0, chk_fail_a}, {28'b0, cf});
      end
    end
    if (chk_done_b) begin
      nchk_b++;
      if (cqb.size() == 0) chk("unexpected chk_done_b", 1, 0);
      else begin
        cf = cqb.pop_front();
        chk("chk_fail_b", {28'b0, chk_fail_b}, {28'b0, cf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; cfg_we = 1'b0; finish_a = 1'b0; finish_b = 1'b0; probe = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '0;
    cfg_ch = '0; rd_ch = '0; rd_sel = '0; cfg_exp = '0;
    idle(2);
    rst_n = 1'b1;
    rd(0, 0, 0, 0, 4'b0000, 4'b0000, "A reset trans");
    rd(1, 0, 0, 0, 4'b0000, 4'b0000, "B reset trans");
    rd(0, 0, 3, 0, 4'b0000, 4'b0000, "A reset max_lat");
    // single transaction on ch0, latency 7
    step(4'b0001, 4'b0000, 4'b0000);
    idle(6);
    step(4'b0000, 4'b0001, 4'b0000);
    rd(0, 0, 0, 1, 4'b0000, 4'b0000, "T1 trans");
    rd(0, 0, 1, 1, 4'b0000, 4'b0000, "T1 done");
    rd(0, 0, 2, 7, 4'b0000, 4'b0000, "T1 last_lat");
    rd(0, 0, 3, 7, 4'b0000, 4'b0000, "T1 max_lat");
    // pipelined ch1: accepts 0,2,4 dones 6,8,10
    for (int k = 0; k <= 10; k++)
      step((k == 0 || k == 2 || k == 4) ? 4'b0010 : 4'b0000,
           (k == 6 || k == 8 || k == 10) ? 4'b0010 : 4'b0000, 4'b0000);
    rd(0, 1, 0, 3, 4'b0000, 4'b0000, "T2 trans");
    rd(0, 1, 2, 2, 4'b0000, 4'b0000, "T2 last_lat");
    rd(0, 1, 3, 6, 4'b0000, 4'b0000, "T2 max_lat");
    repeat (4) step(4'b0010, 4'b0000, 4'b0000);
    rd(0, 1, 0, 7, 4'b0000, 4'b0000, "T2 at MAX_OUT");
    step(4'b0010, 4'b0000, 4'b0000);
    rd(0, 1, 0, 8, 4'b0010, 4'b0000, "T2 over MAX_OUT");
    // same-cycle accept+done while BUSY on ch0
    step(4'b0001, 4'b0000, 4'b0000);
    idle(2);
    step(4'b0001, 4'b0001, 4'b0000);
    idle(1);
    step(4'b0000, 4'b0001, 4'b0000);
    rd(0, 0, 0, 3, 4'b0010, 4'b0000, "BUSY same trans");
    rd(0, 0, 1, 3, 4'b0010, 4'b0000, "BUSY same done");
    rd(0, 0, 2, 2, 4'b0010, 4'b0000, "BUSY same last_lat");
    rd(0, 0, 3, 7, 4'b0010, 4'b0000, "BUSY same max_lat");
    // same-cycle accept+done in IDLE on ch2, then a lone done proves it stayed IDLE
    step(4'b0100, 4'b0100, 4'b0000);
    rd(0, 2, 2, 0, 4'b0010, 4'b0000, "T3 ch2 last_lat");
    rd(0, 2, 0, 1, 4'b0010, 4'b0000, "T3 ch2 trans");
    idle(3);
    step(4'b0000, 4'b0100, 4'b0000);
    rd(0, 2, 1, 2, 4'b0110, 4'b0000, "T3 ch2 stayed idle");
    step(4'b0000, 4'b1000, 4'b0000);
    rd(0, 3, 1, 1, 4'b1110, 4'b0000, "T3 ch3 done");
    rd(0, 3, 0, 0, 4'b1110, 4'b0000, "T3 ch3 trans");
    reset();
    rd(0, 1, 0, 0, 4'b0000, 4'b0000, "A after reset");
    // check: exp={2,1,0,0}, ch0 completes 2
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_exp = 32'd2;
    cyc();
    cfg_ch = 2'd1; cfg_exp = 32'd1;
    cyc();
    cfg_we = 1'b0;
    repeat (2) begin
      step(4'b0001, 4'b0000, 4'b0000);
      idle(2);
      step(4'b0000, 4'b0001, 4'b0000);
    end
    fin(1'b1, 4'b0010, 1'b0, 4'b0000);
    fin(1'b1, 4'b0010, 1'b0, 4'b0000);
    // clear keeps expected counts
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    rd(0, 0, 0, 0, 4'b0000, 4'b0000, "A after clear");
    fin(1'b1, 4'b0011, 1'b0, 4'b0000);
    reset();
    fin(1'b1, 4'b0000, 1'b0, 4'b0000);
    // chain mode: done held without continue
    step(4'b0001, 4'b0000, 4'b0000);
    idle(2);
    repeat (3) step(4'b0000, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0001, 4'b0001);
    rd(1, 0, 0, 1, 4'b0000, 4'b0000, "chain trans");
    rd(1, 0, 1, 1, 4'b0000, 4'b0000, "chain done");
    rd(1, 0, 2, 6, 4'b0000, 4'b0000, "chain last_lat");
    rd(1, 0, 3, 6, 4'b0000, 4'b0000, "chain max_lat");
    reset();
    // saturation with CNT_W=4
    repeat (15) step(4'b0001, 4'b0001, 4'b0001);
    rd(1, 0, 0, 15, 4'b0000, 4'b0000, "sat 15 trans");
    step(4'b0001, 4'b0001, 4'b0001);
    rd(1, 0, 0, 15, 4'b0000, 4'b0001, "sat 16 trans");
    rd(1, 0, 1, 15, 4'b0000, 4'b0001, "sat 16 done");
    // reset while BUSY
    step(4'b0010, 4'b0000, 4'b0000);
    idle(2);
    reset();
    rd(1, 1, 0, 0, 4'b0000, 4'b0000, "B ch1 after reset");
    rd(1, 0, 0, 0, 4'b0000, 4'b0000, "B ch0 after reset");
    rd(1, 0, 3, 0, 4'b0000, 4'b0000, "B max_lat after reset");
    fin(1'b1, 4'b0000, 1'b1, 4'b0000);
    for (int k = 0; k < 20 && (pq.size() + cqa.size() + cqb.size()) != 0; k++) cyc();
    chk("queues drained", pq.size() + cqa.size() + cqb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
